// File: rtl/serial_demux_collector_pkg.sv
// Shared constants and FSM encoding for the serial demux collector.
// Holds the default word width, index-width helper and state type.
package serial_demux_collector_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Index width for a power-of-two word width (never below 1 bit).
    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_demux_collector_demux_1xn.sv
// Combinational 1-to-WIDTH demultiplexer producing one-hot enables.
// All outputs are low when en is low.
module demux_1xn
    import serial_demux_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic          en,
    input  logic [IW-1:0] sel,
    output logic [WIDTH-1:0] onehot
);

    // Steer the enable onto the selected line only.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_demux_collector.sv
// Serial-to-parallel collector: one accepted bit per slot, word out on fill.
// MSB_FIRST_EN: when defined, the first bit of a word lands in slot WIDTH-1.
module serial_demux_collector
    import serial_demux_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_bit,
    input  logic                     clear,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic [idx_w(WIDTH)-1:0]  idx
);

    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx_nx;
    logic [WIDTH-1:0] collect;
    logic [WIDTH-1:0] collect_nx;
    logic [WIDTH-1:0] data_nx;
    logic             valid_nx;
    logic [IW-1:0]    slot;
    logic [WIDTH-1:0] wr_en;
    logic             accept;

    // A bit that arrives together with clear is dropped.
    assign accept = in_valid & ~clear;

`ifdef MSB_FIRST_EN
    assign slot = LAST - idx;
`else
    assign slot = idx;
`endif

    demux_1xn #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_demux (
        .en     (accept),
        .sel    (slot),
        .onehot (wr_en)
    );

    assign busy = (state == COLLECT);

    // Next-state, slot merge and completion decisions.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        collect_nx = collect;
        data_nx    = data_out;
        valid_nx   = 1'b0;
        if (clear) begin
            state_nx   = IDLE;
            idx_nx     = '0;
            collect_nx = '0;
        end else if (in_valid) begin
            collect_nx = (collect & ~wr_en) | (wr_en & {WIDTH{in_bit}});
            if (idx == LAST) begin
                data_nx    = collect_nx;
                valid_nx   = 1'b1;
                idx_nx     = '0;
                state_nx   = IDLE;
                collect_nx = '0;
            end else begin
                idx_nx   = idx + IW'(1);
                state_nx = COLLECT;
            end
        end
    end

    // State, counter and word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            collect   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            collect   <= collect_nx;
            data_out  <= data_nx;
            out_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_serial_demux_collector.sv
// Self-checking bench for serial_demux_collector (directed + random).
// Reference model counts accepted bits and builds words arithmetically.
module tb_serial_demux_collector;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  data_out;
    logic          out_valid;
    logic          busy;
    logic [IW-1:0] idx;

    int total = 0;
    int bad = 0;

    int           m_cnt = 0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_data = '0;
    logic         m_ov = 1'b0;
    int           pulses = 0;

    serial_demux_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear     (clear),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .idx       (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, update model at the edge, compare just after it.
    task automatic step(input logic v, input logic b,
                        input logic c, input logic r);
        int pos;
        in_valid = v;
        in_bit   = b;
        clear    = c;
        reset    = r;
        @(posedge clk);
        m_ov = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_acc = '0;
            m_data = '0;
        end else if (c) begin
            m_cnt = 0;
            m_acc = '0;
        end else if (v) begin
`ifdef MSB_FIRST_EN
            pos = W - 1 - m_cnt;
`else
            pos = m_cnt;
`endif
            m_acc[pos] = b;
            m_cnt++;
            if (m_cnt == W) begin
                m_data = m_acc;
                m_ov = 1'b1;
                m_cnt = 0;
                m_acc = '0;
            end
        end
        #1;
        if (out_valid === 1'b1) pulses++;
        check("data_out", data_out, m_data);
        check("out_valid", out_valid, m_ov);
        check("idx", idx, m_cnt);
        check("busy", busy, m_cnt != 0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) step(1'b1, w[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] exp_word;

        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_data", data_out, 0);

        pulses = 0;
        send_word(8'b0100_1101);
`ifdef MSB_FIRST_EN
        exp_word = 8'hB2;
`else
        exp_word = 8'h4D;
`endif
        check("lsb_word", data_out, exp_word);
        check("lsb_pulse", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lsb_pulses", pulses, 1);
        check("lsb_data_held", data_out, exp_word);

        pulses = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("gap_idx", idx, 4);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ff_word", data_out, 8'hFF);
        send_word(8'h01);
        check("b2b_pulses", pulses, 2);

        held = m_data;
        pulses = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_idx", idx, 0);
        check("clr_data", data_out, held);
        check("clr_pulses", pulses, 0);
        send_word(8'h0F);
        check("clr_then_pulses", pulses, 1);

        held = m_data;
        pulses = 0;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("race_pulses", pulses, 0);
        check("race_data", data_out, held);
        check("race_idx", idx, 0);

        for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_data", data_out, 0);
        check("rst_mid_idx", idx, 0);
        pulses = 0;
        send_word(8'hA5);
        check("a5_word", data_out, 8'hA5);
        check("a5_pulses", pulses, 1);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7,
                 1'($urandom),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_demux_collector.md
# serial_demux_collector

Serial-to-parallel collector that steers a one-bit input stream into a WIDTH-bit word, one slot per accepted bit. A 1-to-WIDTH demultiplexer generates one-hot write enables. It is the receiving end of the mux-based parallel-to-serial path: the mux picks bit S of a word onto one wire, and this block puts the bit on that wire back into slot S. It sits between a serial link or bit-serial datapath stage and the word-wide register or ALU operand inputs.

## Interface
Parameters:
- WIDTH, 8, word width; power of two, 2 to 32; index width is log2(WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state and outputs
- in_valid  in  1  in_bit is valid this cycle; accepted whenever high (no backpressure)
- in_bit  in  1  serial data bit
- clear  in  1  synchronous abort of the partial word
- data_out  out  WIDTH  last completed word, held until next completion
- out_valid  out  1  one-cycle pulse: data_out was updated
- busy  out  1  partial word in progress (idx != 0)
- idx  out  log2(WIDTH)  slot that the next accepted bit writes

## Operation
- Reset value of every output is 0: data_out, out_valid, busy, idx. The internal collect register is also 0.
- The state machine has two states.
  - IDLE: idx = 0. An accepted bit writes slot 0 and moves to COLLECT with idx = 1.
  - COLLECT: each accepted bit writes slot idx, and idx increments.
  - Final slot: the bit accepted at idx = WIDTH-1 completes the word.
    - data_out loads the collect register with the new bit merged into its slot, in the same edge.
    - out_valid pulses.
    - idx wraps to 0 and the state returns to IDLE.
- Slot write: a 1-to-WIDTH demux is driven by idx and gated by in_valid. It produces a one-hot enable, and only the enabled collect bit loads in_bit. All other bits hold.
- Gaps: in_valid low holds idx, state and the collect register indefinitely. There is no timeout.
- Back-to-back words: a bit accepted in the cycle out_valid is high is slot 0 of the next word. No bubble is required.
- clear: idx goes to 0, the state goes to IDLE, and the collect register goes to 0. data_out is untouched and out_valid stays low.
- clear with in_valid in the same cycle: clear wins and the bit is dropped.
- clear in the same cycle as the final bit: clear wins, no completion occurs, and data_out is unchanged.
- Reset mid-word: the partial word is discarded and all outputs are 0 on the next cycle.
- out_valid is never high for two consecutive cycles when WIDTH >= 2.

## Timing
- Input sampling: in_valid, in_bit and clear are sampled at the rising edge of clk.
- Completion latency: the final bit is sampled at edge N. data_out is updated and out_valid is high during cycle N to N+1. out_valid falls at edge N+1 unless that edge completes another word, which is impossible for WIDTH >= 2.
- Word rate: with in_valid held high, one word completes every WIDTH cycles.
- idx and busy: both are registered and reflect the state after the most recent edge.
- No combinational path exists from any input to any output.

## Configuration
- MSB_FIRST_EN is the one compile-time option.
  - Defined: the first accepted bit of a word goes to slot WIDTH-1 and the last to slot 0. The demux is driven by WIDTH-1-idx, and idx still counts 0 to WIDTH-1.
  - Undefined (default): LSB first. The first bit goes to slot 0, so idx = 0 maps to output bit 0.
- The macro does not change idx, busy, out_valid or clear semantics.

## Structure
- Shared package holds:
  - the default word width constant of 8;
  - the index-width constant or function (log2);
  - the state encoding, IDLE = 0 and COLLECT = 1.
- One sub-module, demux_1xn: a combinational 1-to-WIDTH demultiplexer with inputs en, sel[log2(WIDTH)-1:0] and output onehot[WIDTH-1:0].
- The top level holds:
  - the FSM;
  - the idx counter;
  - the collect register;
  - the data_out and out_valid registers.

## Test plan
- Reset: hold reset 2 cycles with in_valid = 1 and in_bit = 1. Required: data_out = 0x00, out_valid = 0, idx = 0 and busy = 0 throughout and for the cycle after release.
- LSB-first word: in_valid held high, in_bit sequence 1,0,1,1,0,0,1,0. Required:
  - data_out = 0x4D with out_valid high for exactly 1 cycle, right after the 8th edge;
  - idx = 0 and busy = 0 afterwards.
  - With MSB_FIRST_EN defined, the same stream gives data_out = 0xB2.
- Gaps and back-to-back words: send 0xFF with in_valid low for 3 cycles between bits 3 and 4, then immediately send 0x01. Required:
  - out_valid pulses for 0xFF, then 8 cycles later for 0x01;
  - idx holds at 4 during the gap.
- clear mid-word: send 5 bits of 1, pulse clear together with in_valid, then send 0x0F. Required:
  - the bit sent with clear is dropped;
  - data_out stays at its prior value with no out_valid;
  - 0x0F then completes normally.
- Final-bit clear race: send 7 bits of 1, then clear together with the 8th bit. Required: no out_valid, data_out unchanged, idx = 0.
- Reset mid-word: send 6 bits, then assert reset for 1 cycle, then send 0xA5. Required: all outputs 0 after reset, then a single completion with data_out = 0xA5.
